// File: rtl/sb_entry_tracker_pkg.sv
// Shared types and constants for the scoreboard entry tracker.
// The per-slot payload (destination register, register file select and
// thread id) is kept as one packed struct so that the top can store and
// export it as a unit.
package sb_entry_tracker_pkg;

  // Architectural register address width (x0..x31 / f0..f31).
  localparam int unsigned REG_ADDR_SIZE = 5;

  // Number of hardware threads sharing the scoreboard.
  localparam int unsigned NUM_THREADS = 2;

  // Thread id width, never narrower than one bit.
  localparam int unsigned TID_BITS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  // Payload recorded for every allocated scoreboard slot.
  typedef struct packed {
    logic [REG_ADDR_SIZE-1:0] rd;
    logic                     rd_fpr;
    logic [TID_BITS-1:0]      tid;
  } sb_track_entry_t;

  // Cleared payload used on reset.
  localparam sb_track_entry_t SB_TRACK_ENTRY_CLEAR = '{
    rd:     {REG_ADDR_SIZE{1'b0}},
    rd_fpr: 1'b0,
    tid:    {TID_BITS{1'b0}}
  };

endpackage : sb_entry_tracker_pkg

// File: rtl/sb_entry_tracker.sv
// Scoreboard entry tracker.
// Allocates slots in program order at the issue pointer, marks them done on
// writeback and retires them in order from the commit pointer. The per-slot
// vectors and the issue pointer feed the RAW dependency checker unchanged:
// valid slots at or above the issue pointer are older than valid slots
// below it, because allocation wraps modulo the slot count.
module sb_entry_tracker
  import sb_entry_tracker_pkg::*;
#(
  parameter int unsigned NR_SB_ENTRIES = 8,
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         flush_i,
  // issue side
  input  logic                                         issue_valid_i,
  output logic                                         issue_ready_o,
  input  logic [REG_ADDR_SIZE-1:0]                     issue_rd_i,
  input  logic                                         issue_rd_fpr_i,
  input  logic [TID_BITS-1:0]                          issue_tid_i,
  output logic [TRANS_ID_BITS-1:0]                     issue_trans_id_o,
  // writeback side
  input  logic                                         wb_valid_i,
  input  logic [TRANS_ID_BITS-1:0]                     wb_trans_id_i,
  // commit side
  output logic                                         commit_valid_o,
  input  logic                                         commit_ready_i,
  output logic [TRANS_ID_BITS-1:0]                     commit_trans_id_o,
  output logic [REG_ADDR_SIZE-1:0]                     commit_rd_o,
  output logic                                         commit_rd_fpr_o,
  output logic [TID_BITS-1:0]                          commit_tid_o,
  // per-entry state exported to the RAW checker
  output logic [NR_SB_ENTRIES-1:0][REG_ADDR_SIZE-1:0]  rd_o,
  output logic [NR_SB_ENTRIES-1:0]                     rd_fpr_o,
  output logic [NR_SB_ENTRIES-1:0][TID_BITS-1:0]       thread_ids_o,
  output logic [NR_SB_ENTRIES-1:0]                     still_issued_o,
  output logic [NR_SB_ENTRIES-1:0]                     done_o,
  output logic [TRANS_ID_BITS-1:0]                     issue_pointer_o
);

  // Occupancy value meaning "every slot allocated".
  localparam logic [TRANS_ID_BITS:0] FULL_COUNT = (TRANS_ID_BITS+1)'(NR_SB_ENTRIES);

  // Pointer step; pointers wrap naturally because the slot count is a power of two.
  localparam logic [TRANS_ID_BITS-1:0] PTR_ONE = TRANS_ID_BITS'(1'b1);

  // Occupancy step.
  localparam logic [TRANS_ID_BITS:0] COUNT_ONE = (TRANS_ID_BITS+1)'(1'b1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NR_SB_ENTRIES-1:0]  valid_r;
  logic [NR_SB_ENTRIES-1:0]  done_r;
  sb_track_entry_t           entry_r [NR_SB_ENTRIES];
  logic [TRANS_ID_BITS-1:0]  issue_ptr_r;
  logic [TRANS_ID_BITS-1:0]  commit_ptr_r;
  logic [TRANS_ID_BITS:0]    count_r;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  logic                      issue_fire_s;
  logic                      commit_fire_s;
  logic [NR_SB_ENTRIES-1:0]  valid_nxt_s;
  logic [NR_SB_ENTRIES-1:0]  done_nxt_s;
  logic [TRANS_ID_BITS:0]    count_nxt_s;
  sb_track_entry_t           issue_entry_s;

  // Handshakes: readiness depends only on occupancy, never on the commit side,
  // so a full tracker that retires this cycle still refuses the new request.
  // A flush suppresses both so no partial update lands alongside the clear.
  always_comb begin
    issue_ready_o  = (count_r != FULL_COUNT);
    commit_valid_o = valid_r[commit_ptr_r] & done_r[commit_ptr_r];
    issue_fire_s   = issue_valid_i & issue_ready_o & ~flush_i;
    commit_fire_s  = commit_valid_o & commit_ready_i & ~flush_i;
  end

  // Per-slot valid/done update. A slot being issued cannot be valid, so a
  // writeback naming it is dropped; a slot being committed loses both bits.
  always_comb begin
    valid_nxt_s = valid_r;
    done_nxt_s  = done_r;
    for (int i = 0; i < NR_SB_ENTRIES; i++) begin
      logic issue_sel;
      logic commit_sel;
      logic wb_sel;
      issue_sel      = issue_fire_s  & (issue_ptr_r   == TRANS_ID_BITS'(i));
      commit_sel     = commit_fire_s & (commit_ptr_r  == TRANS_ID_BITS'(i));
      wb_sel         = wb_valid_i    & (wb_trans_id_i == TRANS_ID_BITS'(i)) & valid_r[i];
      valid_nxt_s[i] = issue_sel | (valid_r[i] & ~commit_sel);
      done_nxt_s[i]  = ~issue_sel & ~commit_sel & (done_r[i] | wb_sel);
    end
  end

  // Occupancy: a simultaneous issue and commit leaves the count unchanged.
  always_comb begin
    case ({issue_fire_s, commit_fire_s})
      2'b10:   count_nxt_s = count_r + COUNT_ONE;
      2'b01:   count_nxt_s = count_r - COUNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Payload captured on an issue.
  always_comb begin
    issue_entry_s.rd     = issue_rd_i;
    issue_entry_s.rd_fpr = issue_rd_fpr_i;
    issue_entry_s.tid    = issue_tid_i;
  end

  // Control state: reset and flush both empty the tracker; otherwise advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r      <= {NR_SB_ENTRIES{1'b0}};
      done_r       <= {NR_SB_ENTRIES{1'b0}};
      issue_ptr_r  <= {TRANS_ID_BITS{1'b0}};
      commit_ptr_r <= {TRANS_ID_BITS{1'b0}};
      count_r      <= {(TRANS_ID_BITS+1){1'b0}};
    end else if (flush_i) begin
      valid_r      <= {NR_SB_ENTRIES{1'b0}};
      done_r       <= {NR_SB_ENTRIES{1'b0}};
      issue_ptr_r  <= {TRANS_ID_BITS{1'b0}};
      commit_ptr_r <= {TRANS_ID_BITS{1'b0}};
      count_r      <= {(TRANS_ID_BITS+1){1'b0}};
    end else begin
      valid_r      <= valid_nxt_s;
      done_r       <= done_nxt_s;
      issue_ptr_r  <= issue_fire_s  ? (issue_ptr_r + PTR_ONE)  : issue_ptr_r;
      commit_ptr_r <= commit_fire_s ? (commit_ptr_r + PTR_ONE) : commit_ptr_r;
      count_r      <= count_nxt_s;
    end
  end

  // Slot payload: cleared on reset, written at the issue pointer on issue.
  // A flush leaves stale payload behind; it is meaningless once valid drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_SB_ENTRIES; i++) begin
        entry_r[i] <= SB_TRACK_ENTRY_CLEAR;
      end
    end else if (issue_fire_s) begin
      entry_r[issue_ptr_r] <= issue_entry_s;
    end else begin
      entry_r[issue_ptr_r] <= entry_r[issue_ptr_r];
    end
  end

  // Export of register state: pointers, head fields and per-slot vectors.
  always_comb begin
    issue_trans_id_o  = issue_ptr_r;
    issue_pointer_o   = issue_ptr_r;
    commit_trans_id_o = commit_ptr_r;
    commit_rd_o       = entry_r[commit_ptr_r].rd;
    commit_rd_fpr_o   = entry_r[commit_ptr_r].rd_fpr;
    commit_tid_o      = entry_r[commit_ptr_r].tid;
    still_issued_o    = valid_r;
    done_o            = done_r;
    for (int i = 0; i < NR_SB_ENTRIES; i++) begin
      rd_o[i]         = entry_r[i].rd;
      rd_fpr_o[i]     = entry_r[i].rd_fpr;
      thread_ids_o[i] = entry_r[i].tid;
    end
  end

endmodule : sb_entry_tracker

// File: tb/tb_sb_entry_tracker.sv
// Directed bench for sb_entry_tracker with eight slots: a hand-written
// sequence for the payload/commit fields, then a table of per-cycle
// vectors covering fill, backpressure, out-of-order writeback, wrap,
// flush and reset.
module tb_sb_entry_tracker;
  import sb_entry_tracker_pkg::*;

  localparam int N  = 8;
  localparam int TB = 3;

  logic                              clk;
  logic                              rst;
  logic                              flush;
  logic                              issue_valid;
  logic                              issue_ready;
  logic [REG_ADDR_SIZE-1:0]          issue_rd;
  logic                              issue_rd_fpr;
  logic [TID_BITS-1:0]               issue_tid;
  logic [TB-1:0]                     issue_trans_id;
  logic                              wb_valid;
  logic [TB-1:0]                     wb_trans_id;
  logic                              commit_valid;
  logic                              commit_ready;
  logic [TB-1:0]                     commit_trans_id;
  logic [REG_ADDR_SIZE-1:0]          commit_rd;
  logic                              commit_rd_fpr;
  logic [TID_BITS-1:0]               commit_tid;
  logic [N-1:0][REG_ADDR_SIZE-1:0]   rd_vec;
  logic [N-1:0]                      rd_fpr_vec;
  logic [N-1:0][TID_BITS-1:0]        tid_vec;
  logic [N-1:0]                      still_issued;
  logic [N-1:0]                      done_vec;
  logic [TB-1:0]                     issue_pointer;

  int tests_run;
  int tests_failed;

  sb_entry_tracker #(.NR_SB_ENTRIES(N)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .issue_valid_i     (issue_valid),
    .issue_ready_o     (issue_ready),
    .issue_rd_i        (issue_rd),
    .issue_rd_fpr_i    (issue_rd_fpr),
    .issue_tid_i       (issue_tid),
    .issue_trans_id_o  (issue_trans_id),
    .wb_valid_i        (wb_valid),
    .wb_trans_id_i     (wb_trans_id),
    .commit_valid_o    (commit_valid),
    .commit_ready_i    (commit_ready),
    .commit_trans_id_o (commit_trans_id),
    .commit_rd_o       (commit_rd),
    .commit_rd_fpr_o   (commit_rd_fpr),
    .commit_tid_o      (commit_tid),
    .rd_o              (rd_vec),
    .rd_fpr_o          (rd_fpr_vec),
    .thread_ids_o      (tid_vec),
    .still_issued_o    (still_issued),
    .done_o            (done_vec),
    .issue_pointer_o   (issue_pointer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                     rst;
    logic                     flush;
    logic                     iv;
    logic [REG_ADDR_SIZE-1:0] rd;
    logic                     wv;
    logic [TB-1:0]            wid;
    logic                     cr;
    logic                     e_ready;
    logic                     e_cv;
    logic [N-1:0]             e_si;
    logic [N-1:0]             e_done;
    logic [TB-1:0]            e_ip;
    logic [TB-1:0]            e_cp;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(input int r, input int f, input int iv, input int rd,
                              input int wv, input int wid, input int cr,
                              input int e_ready, input int e_cv, input int e_si,
                              input int e_done, input int e_ip, input int e_cp);
    vec_t v;
    v.rst     = 1'(r);
    v.flush   = 1'(f);
    v.iv      = 1'(iv);
    v.rd      = REG_ADDR_SIZE'(rd);
    v.wv      = 1'(wv);
    v.wid     = TB'(wid);
    v.cr      = 1'(cr);
    v.e_ready = 1'(e_ready);
    v.e_cv    = 1'(e_cv);
    v.e_si    = N'(e_si);
    v.e_done  = N'(e_done);
    v.e_ip    = TB'(e_ip);
    v.e_cp    = TB'(e_cp);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst          = 1'b0;
    flush        = 1'b0;
    issue_valid  = 1'b0;
    issue_rd     = '0;
    issue_rd_fpr = 1'b0;
    issue_tid    = '0;
    wb_valid     = 1'b0;
    wb_trans_id  = '0;
    commit_ready = 1'b0;
  endtask

  // One clock: inputs were set before the rising edge, outputs sampled 1 after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle_inputs();
    rst = 1'b1;

    // Vectors: rst flush iv rd wv wid cr | ready cv still_issued done ip cp
    vecs[0]  = mk(1,0,0, 0, 0,0,0, 1,0,'h00,'h00,0,0);
    vecs[1]  = mk(0,0,1, 5, 0,0,0, 1,0,'h01,'h00,1,0);
    vecs[2]  = mk(0,0,1, 6, 0,0,0, 1,0,'h03,'h00,2,0);
    vecs[3]  = mk(0,0,1, 7, 0,0,0, 1,0,'h07,'h00,3,0);
    vecs[4]  = mk(0,0,1, 8, 0,0,0, 1,0,'h0F,'h00,4,0);
    vecs[5]  = mk(0,0,1, 9, 0,0,0, 1,0,'h1F,'h00,5,0);
    vecs[6]  = mk(0,0,1,10, 0,0,0, 1,0,'h3F,'h00,6,0);
    vecs[7]  = mk(0,0,1,11, 0,0,0, 1,0,'h7F,'h00,7,0);
    vecs[8]  = mk(0,0,1,12, 0,0,0, 0,0,'hFF,'h00,0,0);
    vecs[9]  = mk(0,0,1,13, 0,0,0, 0,0,'hFF,'h00,0,0);  // ninth request held
    vecs[10] = mk(0,0,0, 0, 1,2,0, 0,0,'hFF,'h04,0,0);  // slot 2 done, head not
    vecs[11] = mk(0,0,0, 0, 1,0,1, 0,1,'hFF,'h05,0,0);  // head done now
    vecs[12] = mk(0,0,1,14, 0,0,1, 1,0,'hFE,'h04,0,1);  // commit while full: no issue
    vecs[13] = mk(0,0,1,15, 0,0,1, 0,0,'hFF,'h04,1,1);  // issue wraps into slot 0
    vecs[14] = mk(0,0,0, 0, 1,1,0, 0,1,'hFF,'h06,1,1);
    vecs[15] = mk(0,0,0, 0, 0,0,1, 1,1,'hFD,'h04,1,2);
    vecs[16] = mk(0,0,0, 0, 0,0,1, 1,0,'hF9,'h00,1,3);
    vecs[17] = mk(0,0,0, 0, 1,3,1, 1,1,'hF9,'h08,1,3);
    vecs[18] = mk(0,1,1,16, 1,4,1, 1,0,'h00,'h00,0,0);  // flush beats issue/wb/commit
    vecs[19] = mk(0,0,0, 0, 1,4,0, 1,0,'h00,'h00,0,0);  // writeback to empty slot
    vecs[20] = mk(0,0,1, 0, 0,0,0, 1,0,'h01,'h00,1,0);  // x0 still allocated
    vecs[21] = mk(0,0,1, 1, 1,0,0, 1,1,'h03,'h01,2,0);
    vecs[22] = mk(1,0,1, 2, 1,1,1, 1,0,'h00,'h00,0,0);  // reset mid-operation

    // ---- Hand-written sequence: payload vectors and head fields ----
    tick();
    chk("rst_ready", 64'(issue_ready), 64'(1'b1));
    chk("rst_trans_id", 64'(issue_trans_id), 64'(3'd0));
    chk("rst_rd_vec", 64'(rd_vec), 64'(40'h0));
    @(negedge clk);
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd5; issue_rd_fpr = 1'b0; issue_tid = 1'b0;
    tick();
    @(negedge clk);
    issue_rd = 5'd6; issue_rd_fpr = 1'b1; issue_tid = 1'b1;
    tick();
    @(negedge clk);
    issue_rd = 5'd7; issue_rd_fpr = 1'b0; issue_tid = 1'b1;
    tick();
    chk("rd_slot1", 64'(rd_vec[1]), 64'(5'd6));
    chk("rd_fpr_vec", 64'(rd_fpr_vec), 64'(8'h02));
    chk("tid_vec", 64'(tid_vec), 64'(8'h06));
    chk("issue_trans_id", 64'(issue_trans_id), 64'(3'd3));
    chk("still_issued_3", 64'(still_issued), 64'(8'h07));
    @(negedge clk);
    idle_inputs();
    wb_valid = 1'b1; wb_trans_id = 3'd0;
    tick();
    chk("head0_valid", 64'(commit_valid), 64'(1'b1));
    chk("head0_rd", 64'(commit_rd), 64'(5'd5));
    chk("head0_fpr", 64'(commit_rd_fpr), 64'(1'b0));
    chk("head0_tid", 64'(commit_tid), 64'(1'b0));
    @(negedge clk);
    wb_trans_id = 3'd1; commit_ready = 1'b1;
    tick();
    chk("head1_id", 64'(commit_trans_id), 64'(3'd1));
    chk("head1_valid", 64'(commit_valid), 64'(1'b1));
    chk("head1_rd", 64'(commit_rd), 64'(5'd6));
    chk("head1_fpr", 64'(commit_rd_fpr), 64'(1'b1));
    chk("head1_tid", 64'(commit_tid), 64'(1'b1));
    chk("done_after_commit", 64'(done_vec), 64'(8'h02));
    chk("valid_after_commit", 64'(still_issued), 64'(8'h06));

    // ---- Table-driven per-cycle vectors ----
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      rst          = vecs[i].rst;
      flush        = vecs[i].flush;
      issue_valid  = vecs[i].iv;
      issue_rd     = vecs[i].rd;
      issue_rd_fpr = 1'b0;
      issue_tid    = '0;
      wb_valid     = vecs[i].wv;
      wb_trans_id  = vecs[i].wid;
      commit_ready = vecs[i].cr;
      tick();
      chk($sformatf("v%0d_ready", i), 64'(issue_ready), 64'(vecs[i].e_ready));
      chk($sformatf("v%0d_commit_valid", i), 64'(commit_valid), 64'(vecs[i].e_cv));
      chk($sformatf("v%0d_still_issued", i), 64'(still_issued), 64'(vecs[i].e_si));
      chk($sformatf("v%0d_done", i), 64'(done_vec), 64'(vecs[i].e_done));
      chk($sformatf("v%0d_issue_ptr", i), 64'(issue_pointer), 64'(vecs[i].e_ip));
      chk($sformatf("v%0d_commit_id", i), 64'(commit_trans_id), 64'(vecs[i].e_cp));
    end

    // Reset also clears the payload registers.
    chk("rst_rd_vec_end", 64'(rd_vec), 64'(40'h0));
    chk("rst_trans_id_end", 64'(issue_trans_id), 64'(3'd0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sb_entry_tracker
